// File: rtl/inst_decode_stage.sv
// inst_decode_stage
//
// Decode stage that feeds the 8-entry, 16-bit register file. It accepts a
// 16-bit instruction word over a valid/ready handshake. It registers the
// decoded fields on the rising edge, so the register file can sample the
// selects on the following falling edge.
//
// Optional feature: define DECODE_SCOREBOARD_EN to build the per-register
// busy scoreboard. The scoreboard is set when an instruction that writes rD
// is accepted. It is cleared by the writeback port, or by a flush of the
// held instruction. While a read or write register is still busy, incoming
// instructions stall (RAW/WAW). Without the macro, hazard detection is
// absent and the writeback port is ignored.
//
// Ports
//   I_clk, I_rst         clock (posedge), asynchronous active-high reset
//   I_inst               instruction: [15:12] op, [11:9] rD, [8] flag,
//                        [7:5] rA, [4:2] rB, [7:0] imm8
//   I_inst_valid         upstream word valid
//   o_inst_ready         stage accepts a word this cycle
//   o_dec_valid          decoded output valid
//   I_dec_ready          downstream takes the decoded output
//   I_flush              drop the held decoded instruction
//   I_wb_valid/I_wb_sel  writeback of a register completes this cycle
//   o_selA/B/D           register selects (raw instruction fields)
//   o_aluop, o_flag      opcode and flag passthrough
//   o_imm                decoded immediate
//   o_regwe              instruction writes rD
//   o_illegal            opcode 1110 or 1111
module inst_decode_stage #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 3
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [DATA_W-1:0] I_inst,
  input  logic              I_inst_valid,
  output logic              o_inst_ready,
  output logic              o_dec_valid,
  input  logic              I_dec_ready,
  input  logic              I_flush,
  input  logic              I_wb_valid,
  input  logic [SEL_W-1:0]  I_wb_sel,
  output logic [SEL_W-1:0]  o_selA,
  output logic [SEL_W-1:0]  o_selB,
  output logic [SEL_W-1:0]  o_selD,
  output logic [3:0]        o_aluop,
  output logic              o_flag,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_regwe,
  output logic              o_illegal
);

  localparam int NREG = 1 << SEL_W;

  function automatic logic writes_rd(input logic [3:0] op);
    writes_rd = (op <= 4'h6) || ((op >= 4'h8) && (op <= 4'hB));
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    is_illegal = (op >= 4'hE);
  endfunction

  function automatic logic [DATA_W-1:0] decode_imm(input logic [DATA_W-1:0] inst);
    logic [7:0] imm8;
    imm8 = inst[7:0];
    case (inst[15:12])
      4'h8:       decode_imm = inst[8] ? {imm8, {(DATA_W-8){1'b0}}}
                                       : {{(DATA_W-8){1'b0}}, imm8};
      4'hC, 4'hD: decode_imm = {{(DATA_W-8){1'b0}}, imm8};
      default:    decode_imm = {{(DATA_W-5){1'b0}}, inst[4:0]};
    endcase
  endfunction

  logic [3:0]       op_in;
  logic [SEL_W-1:0] rd_in;
  logic [SEL_W-1:0] ra_in;
  logic [SEL_W-1:0] rb_in;
  logic             hazard;
  logic             accept;

  logic              vld_p0;
  logic [SEL_W-1:0]  sel_a_p0;
  logic [SEL_W-1:0]  sel_b_p0;
  logic [SEL_W-1:0]  sel_d_p0;
  logic [3:0]        aluop_p0;
  logic              flag_p0;
  logic [DATA_W-1:0] imm_p0;
  logic              regwe_p0;
  logic              illegal_p0;

  assign op_in = I_inst[15:12];
  assign rd_in = I_inst[11:9];
  assign ra_in = I_inst[7:5];
  assign rb_in = I_inst[4:2];

`ifdef DECODE_SCOREBOARD_EN
  function automatic logic reads_ra(input logic [3:0] op);
    reads_ra = (op <= 4'h7) || ((op >= 4'h9) && (op <= 4'hB)) || (op == 4'hD);
  endfunction

  function automatic logic reads_rb(input logic [3:0] op);
    reads_rb = (op <= 4'h4) || (op == 4'h7) || ((op >= 4'h9) && (op <= 4'hB))
               || (op == 4'hD);
  endfunction

  logic [NREG-1:0] busy;
  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] drop_mask;

  // A writeback landing this cycle already resolves the hazard.
  always_comb begin
    wb_mask  = I_wb_valid ? (NREG'(1) << I_wb_sel) : '0;
    busy_eff = busy & ~wb_mask;
    hazard   = (reads_ra(op_in)  && busy_eff[ra_in]) ||
               (reads_rb(op_in)  && busy_eff[rb_in]) ||
               (writes_rd(op_in) && busy_eff[rd_in]);
    set_mask = (accept && writes_rd(op_in)) ? (NREG'(1) << rd_in) : '0;
    // A dropped writer never writes back, so its busy bit is released here.
    // An instruction handed off in the flush cycle is not dropped.
    drop_mask = (I_flush && vld_p0 && !I_dec_ready && regwe_p0)
                ? (NREG'(1) << sel_d_p0) : '0;
  end

  // The set mask is applied last, so a new writer wins over a same-cycle clear.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~wb_mask & ~drop_mask) | set_mask;
    end
  end
`else
  logic unused_wb;
  assign unused_wb = ^{I_wb_valid, I_wb_sel};
  assign hazard    = 1'b0;
`endif

  // The hazard term uses only the word's fields, never I_inst_valid.
  assign o_inst_ready = !I_flush && !hazard && (!vld_p0 || I_dec_ready);
  assign accept       = I_inst_valid && o_inst_ready;

  // ---- stage p0: decoded fields presented to the register file ----
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      vld_p0     <= 1'b0;
      sel_a_p0   <= '0;
      sel_b_p0   <= '0;
      sel_d_p0   <= '0;
      aluop_p0   <= '0;
      flag_p0    <= 1'b0;
      imm_p0     <= '0;
      regwe_p0   <= 1'b0;
      illegal_p0 <= 1'b0;
    end else if (accept) begin
      vld_p0     <= 1'b1;
      sel_a_p0   <= ra_in;
      sel_b_p0   <= rb_in;
      sel_d_p0   <= rd_in;
      aluop_p0   <= op_in;
      flag_p0    <= I_inst[8];
      imm_p0     <= decode_imm(I_inst);
      regwe_p0   <= writes_rd(op_in);
      illegal_p0 <= is_illegal(op_in);
    end else if (I_flush || I_dec_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign o_dec_valid = vld_p0;
  assign o_selA      = sel_a_p0;
  assign o_selB      = sel_b_p0;
  assign o_selD      = sel_d_p0;
  assign o_aluop     = aluop_p0;
  assign o_flag      = flag_p0;
  assign o_imm       = imm_p0;
  assign o_regwe     = regwe_p0;
  assign o_illegal   = illegal_p0;

endmodule
